bus_master_if: RTL and testbench
================================

Name: bus_master_if

Overview:
- Initiator-side bus interface: takes one word read/write request from a core-side client, arbitrates for the shared bus, and drives the address/strobe/write data.
- Waits for the selected slave's ready, then returns read data and a completion pulse to the client.
- Sits between a bus master (CPU fetch/mem stage, DMA) and the bus arbiter/address decoder.
- Consumes the muxed slave return path (read data + ready) that the bus slave multiplexer produces.

Parameters:
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, max ACCESS cycles before abort (used only with BUS_TIMEOUT_EN); counter is 8 bits wide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req  in  1  client request strobe, sampled only when busy=0
- rw  in  1  1=read, 0=write
- addr  in  ADDR_W  client word address
- wr_data  in  DATA_W  client write data
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- rd_data  out  DATA_W  captured read data, held until next read completes
- err  out  1  timeout abort flag, pulses with done (tied 0 without BUS_TIMEOUT_EN)
- bus_req_  out  1  bus request, active-low
- bus_grnt_  in  1  bus grant, active-low
- bus_addr  out  ADDR_W  bus address
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  bus read/write, 1=read
- bus_wr_data  out  DATA_W  bus write data
- bus_rd_data  in  DATA_W  muxed slave read data
- bus_rdy_  in  1  muxed slave ready, active-low

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, err=0, rd_data=0, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0; state=IDLE.
- IDLE:
  - If req=1, latch rw/addr/wr_data, set busy=1 and bus_req_=0, go REQ.
  - Otherwise hold bus outputs at their reset values.
- REQ:
  - Hold bus_req_=0.
  - When bus_grnt_=0 is sampled, drive bus_as_=0 with the latched bus_addr/bus_rw/bus_wr_data, go ACCESS.
- ACCESS:
  - Hold bus_req_=0, bus_as_=0 and the address/data/rw outputs stable.
  - When bus_rdy_=0 is sampled: if read, capture bus_rd_data into rd_data; then done=1, busy=0, bus_req_=1, bus_as_=1, and the address/data/rw outputs return to reset values; go IDLE.
- Minimum latency (grant and ready both immediate): req sampled at edge 0, bus_req_ low after edge 0, bus_as_ low after edge 1, done high after edge 2. That is 3 cycles req-to-done; each slave wait cycle adds 1.
- A req in the cycle where done=1 is accepted, giving back-to-back transactions with no dead cycle.
- req while busy=1 is ignored; the client must wait for done.
- Grant is non-preemptive: bus_grnt_ deasserting during ACCESS is ignored, and the access completes on ready.
- Writes leave rd_data unchanged.
- bus_rdy_ is ignored outside ACCESS.
- bus_rdy_ sampled low together with the grant in REQ does not complete the access; completion requires ACCESS state.
- Reset mid-transaction aborts immediately: next cycle all outputs are at reset values, no done pulse, state=IDLE.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYC with ready still high, the access is aborted: done=1 and err=1 for one cycle, rd_data is unchanged, bus signals are released, go IDLE.
  - Ready on the same cycle as the limit wins: normal completion, err=0.
- Without the macro: no counter; ACCESS waits indefinitely; err is constant 0.

Decomposition:
- Shared bus header/package holds:
  - state encoding (IDLE=2'h0, REQ=2'h1, ACCESS=2'h2)
  - READ=1'b1, WRITE=1'b0
  - ENABLE_/DISABLE_ active-low levels
  - word address/data width macros
- Single module. The timeout counter is small and stays inline; no sub-module.

Test Plan:
- Zero-wait read: req, rw=1, addr=30'h10; grant and rdy_ tied low; bus_rd_data=32'hDEADBEEF -> done exactly 3 cycles after req, rd_data=32'hDEADBEEF, bus_as_ low for exactly 1 cycle.
- Write with 4 wait states and a 2-cycle grant delay: wr_data=32'h12345678 -> bus_wr_data stable throughout ACCESS, done at cycle 3+2+4=9, rd_data unchanged.
- Back-to-back: second req issued in the done cycle -> bus_req_ stays low continuously, second done 3 cycles after the first.
- req during busy (addr=30'h55) -> ignored; the bus carries only the first address; exactly one done.
- Reset asserted mid-ACCESS -> next cycle bus_req_=1, bus_as_=1, busy=0; no done pulse; a new req after release completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=8, rdy_ held high -> done=1 and err=1 after 8 ACCESS cycles, bus released, rd_data unchanged. Second run with rdy_ low on cycle 8 -> err=0, normal completion.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// bus_master_if_pkg: shared bus encodings, active-low levels and default widths for bus_master_if.
package bus_master_if_pkg;
  localparam int ADDR_W_DEF = 30;
  localparam int DATA_W_DEF = 32;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'h0, REQ = 2'h1, ACCESS = 2'h2} state_e;
endpackage

// File: rtl/bus_master_if_if.sv
// bus_master_if_if: client request/response and shared-bus signals of one bus initiator.
interface bus_master_if_if import bus_master_if_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic req;
  logic rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic busy;
  logic done;
  logic [DATA_W-1:0] rd_data;
  logic err;
  logic bus_req_;
  logic bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic bus_as_;
  logic bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic bus_rdy_;
  modport master (
    input req, rw, addr, wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    output busy, done, rd_data, err, bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );
  modport slave (
    output req, rw, addr, wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    input busy, done, rd_data, err, bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );
endinterface

// File: rtl/bus_master_if.sv
// bus_master_if: single-word bus initiator (request, grant, strobe, wait for ready); all outputs registered.
// Optional access timeout abort enabled by defining BUS_TIMEOUT_EN.
module bus_master_if import bus_master_if_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic reset,
  bus_master_if_if.master b
);
  state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic bus_req_q, bus_req_d, bus_as_q, bus_as_d, bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d, lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d, lat_wd_q, lat_wd_d;
  logic lat_rw_q, lat_rw_d;
  logic fin;
`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    rd_data_d = rd_data_q;
    bus_req_d = bus_req_q;
    bus_as_d = bus_as_q;
    bus_rw_d = bus_rw_q;
    bus_addr_d = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    lat_rw_d = lat_rw_q;
    lat_addr_d = lat_addr_q;
    lat_wd_d = lat_wd_q;
    fin = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (b.req) begin
        lat_rw_d = b.rw;
        lat_addr_d = b.addr;
        lat_wd_d = b.wr_data;
        busy_d = 1'b1;
        bus_req_d = ENABLE_;
        state_d = REQ;
      end
      REQ: if (b.bus_grnt_ == ENABLE_) begin
        bus_as_d = ENABLE_;
        bus_rw_d = lat_rw_q;
        bus_addr_d = lat_addr_q;
        bus_wr_data_d = lat_wd_q;
        state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
      end
      ACCESS: begin
        if (b.bus_rdy_ == ENABLE_) begin
          rd_data_d = (bus_rw_q == READ) ? b.bus_rd_data : rd_data_q;
          fin = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TO_LIM) begin
          err_d = 1'b1;
          fin = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      bus_req_d = DISABLE_;
      bus_as_d = DISABLE_;
      bus_rw_d = READ;
      bus_addr_d = '0;
      bus_wr_data_d = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rd_data_q <= '0;
      bus_req_q <= DISABLE_;
      bus_as_q <= DISABLE_;
      bus_rw_q <= READ;
      bus_addr_q <= '0;
      bus_wr_data_q <= '0;
      lat_rw_q <= READ;
      lat_addr_q <= '0;
      lat_wd_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      rd_data_q <= rd_data_d;
      bus_req_q <= bus_req_d;
      bus_as_q <= bus_as_d;
      bus_rw_q <= bus_rw_d;
      bus_addr_q <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      lat_rw_q <= lat_rw_d;
      lat_addr_q <= lat_addr_d;
      lat_wd_q <= lat_wd_d;
    end
  end
`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) cnt_q <= reset ? 8'd0 : cnt_d;
`endif
  assign b.busy = busy_q;
  assign b.done = done_q;
  assign b.rd_data = rd_data_q;
  assign b.err = err_q;
  assign b.bus_req_ = bus_req_q;
  assign b.bus_as_ = bus_as_q;
  assign b.bus_rw = bus_rw_q;
  assign b.bus_addr = bus_addr_q;
  assign b.bus_wr_data = bus_wr_data_q;
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: randomized transactions checked against a per-transaction timeline model.
module tb_bus_master_if;
  localparam int T = 8;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  bus_master_if_if #(.ADDR_W(30), .DATA_W(32)) bif();
  bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT_CYC(T)) dut (.clk(clk), .reset(reset), .b(bif));
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rd_model = '0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, ".busy"}, 64'(bif.busy), 64'(1'b0));
    chk({tag, ".done"}, 64'(bif.done), 64'(1'b0));
    chk({tag, ".err"}, 64'(bif.err), 64'(1'b0));
    chk({tag, ".bus_req_"}, 64'(bif.bus_req_), 64'(1'b1));
    chk({tag, ".bus_as_"}, 64'(bif.bus_as_), 64'(1'b1));
    chk({tag, ".bus_rw"}, 64'(bif.bus_rw), 64'(1'b1));
    chk({tag, ".bus_addr"}, 64'(bif.bus_addr), 64'(0));
    chk({tag, ".bus_wr_data"}, 64'(bif.bus_wr_data), 64'(0));
    chk({tag, ".rd_data"}, 64'(bif.rd_data), 64'(rd_model));
  endtask
  task automatic idle_cyc(input string tag);
    bif.req = 1'b0;
    bif.bus_grnt_ = 1'($urandom);
    bif.bus_rdy_ = 1'($urandom);
    bif.bus_rd_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    idle_chk(tag);
  endtask
  // Edge 0 samples req; grant seen at edge 1+g; ACCESS spans cycles 2+g..last; done in cycle last+1.
  task automatic txn(input string tag, input logic rw, input logic [29:0] a, input logic [31:0] wd,
                     input int g, input int w, input logic [31:0] rdv);
    bit abort;
    int last, as0, c;
    bit in_acc;
    abort = TO_EN && w >= T;
    as0 = 2 + g;
    last = as0 + (abort ? T - 1 : w);
    for (int e = 0; e <= last; e++) begin
      bif.req = (e == 0) ? 1'b1 : 1'($urandom);
      bif.addr = (e == 0) ? a : 30'h55;
      bif.rw = (e == 0) ? rw : 1'($urandom);
      bif.wr_data = (e == 0) ? wd : $urandom;
      bif.bus_grnt_ = (e < 1 + g) ? 1'b1 : (e < as0) ? 1'b0 : 1'($urandom);
      bif.bus_rdy_ = (e < as0) ? 1'($urandom) : (e == last && !abort) ? 1'b0 : 1'b1;
      bif.bus_rd_data = (e == last) ? rdv : $urandom;
      @(posedge clk);
      @(negedge clk);
      c = e + 1;
      in_acc = c >= as0 && c <= last;
      chk({tag, ".busy"}, 64'(bif.busy), 64'(c <= last));
      chk({tag, ".done"}, 64'(bif.done), 64'(c == last + 1));
      chk({tag, ".err"}, 64'(bif.err), 64'(c == last + 1 && abort));
      chk({tag, ".bus_req_"}, 64'(bif.bus_req_), 64'(c > last));
      chk({tag, ".bus_as_"}, 64'(bif.bus_as_), 64'(!in_acc));
      chk({tag, ".bus_addr"}, 64'(bif.bus_addr), 64'(in_acc ? a : 30'h0));
      chk({tag, ".bus_rw"}, 64'(bif.bus_rw), 64'(in_acc ? rw : 1'b1));
      chk({tag, ".bus_wr_data"}, 64'(bif.bus_wr_data), 64'(in_acc ? wd : 32'h0));
      chk({tag, ".rd_data"}, 64'(bif.rd_data),
          64'((c == last + 1 && rw && !abort) ? rdv : rd_model));
    end
    if (rw && !abort) rd_model = rdv;
  endtask
  initial begin
    reset = 1'b1;
    bif.req = 1'b0;
    bif.rw = 1'b0;
    bif.addr = '0;
    bif.wr_data = '0;
    bif.bus_grnt_ = 1'b1;
    bif.bus_rdy_ = 1'b1;
    bif.bus_rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");
    reset = 1'b0;
    idle_cyc("idle0");
    txn("zw_read", 1'b1, 30'h10, $urandom, 0, 0, 32'hDEADBEEF);
    idle_cyc("gap1");
    txn("wait_write", 1'b0, 30'h20, 32'h12345678, 2, 4, $urandom);
    idle_cyc("gap2");
    txn("b2b_a", 1'b1, 30'h31, $urandom, 0, 0, 32'hCAFE0001);
    txn("b2b_b", 1'b0, 30'h32, 32'hA5A5A5A5, 0, 0, $urandom);
    txn("b2b_c", 1'b1, 30'h33, $urandom, 1, 2, 32'h0BADF00D);
    // Reset during ACCESS: released outputs next cycle, no done, rd_data cleared.
    bif.req = 1'b1; bif.rw = 1'b1; bif.addr = 30'h44; bif.bus_grnt_ = 1'b0; bif.bus_rdy_ = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid.as_low", 64'(bif.bus_as_), 64'(1'b0));
    reset = 1'b1;
    bif.bus_rdy_ = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd_model = '0;
    idle_chk("mid_reset");
    reset = 1'b0;
    idle_cyc("after_reset");
    txn("post_reset", 1'b1, 30'h45, $urandom, 1, 1, 32'h13579BDF);
    if (TO_EN) begin
      idle_cyc("gap_to");
      txn("timeout", 1'b1, 30'h50, $urandom, 1, 20, 32'hFFFF0000);
      txn("ready_at_limit", 1'b1, 30'h51, $urandom, 0, T - 1, 32'h600DCAFE);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle_cyc("rnd_gap");
      txn("rnd", 1'($urandom), 30'($urandom), $urandom, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 5)), $urandom);
    end
    idle_cyc("final");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
